// File: rtl/mmu_result_drain.sv
// Result drain for the 2x2 systolic MMU: waits for the accumulators to settle,
// captures and clears them, then streams the four results out as bytes.
module mmu_result_drain #(
    parameter int ACC_W     = 16,
    parameter int DRAIN_LAT = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ACC_W-1:0] c00,
    input  logic [ACC_W-1:0] c01,
    input  logic [ACC_W-1:0] c10,
    input  logic [ACC_W-1:0] c11,
    output logic             clear_out,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    // Handshake: a byte transfers on a rising edge where out_valid && out_ready;
    // out_data is held stable while out_valid && !out_ready.

    localparam int BPR   = ACC_W / 8;
    localparam int NB    = 4 * BPR;
    localparam int IDX_W = $clog2(NB);
    localparam int CNT_W = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_LAT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [4*ACC_W-1:0] cap_q, cap_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               clear_out_q, clear_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [IDX_W-1:0]   idx_nxt;
    logic [7:0]         cap_bytes [NB];

    // Results are packed c00 at the bottom, so byte k of the packed word is
    // exactly the k-th byte of the little-endian stream.
    always_comb begin
        for (int k = 0; k < NB; k++) begin
            cap_bytes[k] = cap_q[8*k +: 8];
        end
    end

    assign idx_nxt = idx_q + IDX_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        cap_d       = cap_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        clear_out_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // First byte comes straight from c00 so it is valid on the capture edge.
                    cap_d       = {c11, c10, c01, c00};
                    out_data_d  = c00[7:0];
                    out_valid_d = 1'b1;
                    clear_out_d = 1'b1;
                    idx_d       = '0;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                if (out_valid_q && out_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        out_data_d  = 8'h00;
                        idx_d       = '0;
                        done_d      = 1'b1;
                    end else begin
                        idx_d      = idx_nxt;
                        out_data_d = cap_bytes[idx_nxt];
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            cap_q       <= '0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            clear_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            cap_q       <= cap_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            clear_out_q <= clear_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign clear_out = clear_out_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mmu_result_drain.sv
// Directed bench for mmu_result_drain: expected bytes are queued when a run is
// started and compared by a monitor as each byte is accepted downstream.
module tb_mmu_result_drain;

    localparam int ACC_W = 16;
    localparam int DL    = 5;
    localparam int BPR   = ACC_W / 8;
    localparam int NB    = 4 * BPR;

    logic             clk;
    logic             rst;
    logic             start;
    logic [ACC_W-1:0] c00, c01, c10, c11;
    logic             clear_out;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int n_wait;
    int dc_snap;

    logic [7:0] exp_q[$];
    logic [7:0] held;
    logic [7:0] exp_b;
    bit         stalled = 0;

    mmu_result_drain #(.ACC_W(ACC_W), .DRAIN_LAT(DL)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .c00       (c00),
        .c01       (c01),
        .c10       (c10),
        .c11       (c11),
        .clear_out (clear_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_stream(input logic [ACC_W-1:0] r0, input logic [ACC_W-1:0] r1,
                               input logic [ACC_W-1:0] r2, input logic [ACC_W-1:0] r3);
        logic [ACC_W-1:0] rs [4];
        rs[0] = r0; rs[1] = r1; rs[2] = r2; rs[3] = r3;
        for (int r = 0; r < 4; r++) begin
            for (int b = 0; b < BPR; b++) begin
                exp_q.push_back(rs[r][8*b +: 8]);
            end
        end
    endtask

    task automatic set_c(input logic [ACC_W-1:0] r0, input logic [ACC_W-1:0] r1,
                         input logic [ACC_W-1:0] r2, input logic [ACC_W-1:0] r3);
        c00 = r0; c01 = r1; c10 = r2; c11 = r3;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: ready high, 1: ready pattern 1,0,0,1,..., 2: random ready
    task automatic wait_done(input int mode, input bit chk_busy, output int n);
        n = 0;
        while (!done && n < 200) begin
            case (mode)
                1:       out_ready = ((n % 4) == 0) || ((n % 4) == 3);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
            tick();
            n++;
            if (!done && chk_busy) check("busy_while_running", busy, 1);
        end
        checks++;
        assert (n < 200) else begin
            failures++;
            $error("FAIL done_timeout observed=%0d cycles expected=<200", n);
        end
        out_ready = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stalled = 0;
        end else begin
            if (stalled && out_valid) check("stall_hold", out_data, held);
            if (out_valid && out_ready) begin
                checks++;
                assert (exp_q.size() > 0) else begin
                    failures++;
                    $error("FAIL unexpected_byte observed=%0h expected=none", out_data);
                end
                if (exp_q.size() > 0) begin
                    exp_b = exp_q.pop_front();
                    check("byte", out_data, exp_b);
                end
                stalled = 0;
            end else begin
                stalled = out_valid;
                held    = out_data;
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        set_c('0, '0, '0, '0);
        repeat (3) tick();
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_clear", clear_out, 0);
        check("rst_data", out_data, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // Basic drain
        set_c(16'h1234, 16'h00FF, 16'h8001, 16'hFFFF);
        out_ready = 1'b1;
        push_stream(16'h1234, 16'h00FF, 16'h8001, 16'hFFFF);
        pulse_start();
        check("wait_busy", busy, 1);
        check("wait_valid", out_valid, 0);
        repeat (DL - 1) tick();
        check("pre_capture_valid", out_valid, 0);
        tick();
        check("capture_valid", out_valid, 1);
        check("capture_clear", clear_out, 1);
        check("capture_byte0", out_data, 8'h34);
        tick();
        check("clear_one_cycle", clear_out, 0);
        check("second_byte", out_data, 8'h12);
        wait_done(0, 1, n_wait);
        check("done_latency", n_wait, NB - 1);
        check("done_busy_low", busy, 0);
        check("done_valid_low", out_valid, 0);
        tick();
        check("done_one_cycle", done, 0);
        check("basic_q_empty", exp_q.size(), 0);
        check("basic_done_cnt", done_cnt, 1);

        // Backpressure
        push_stream(16'h1234, 16'h00FF, 16'h8001, 16'hFFFF);
        pulse_start();
        wait_done(1, 1, n_wait);
        tick();
        check("bp_q_empty", exp_q.size(), 0);
        check("bp_done_cnt", done_cnt, 2);

        // Late input change after capture
        push_stream(16'h1234, 16'h00FF, 16'h8001, 16'hFFFF);
        pulse_start();
        repeat (DL) tick();
        tick();
        c00 = 16'hAAAA;
        wait_done(0, 1, n_wait);
        tick();
        check("late_q_empty", exp_q.size(), 0);
        check("late_done_cnt", done_cnt, 3);

        // Start ignored in WAIT and SEND
        set_c(16'h1234, 16'h00FF, 16'h8001, 16'hFFFF);
        push_stream(16'h1234, 16'h00FF, 16'h8001, 16'hFFFF);
        out_ready = 1'b0;
        pulse_start();
        tick();
        pulse_start();
        repeat (DL - 2) tick();
        check("ign_capture_valid", out_valid, 1);
        check("ign_capture_byte0", out_data, 8'h34);
        repeat (2) tick();
        pulse_start();
        check("ign_busy_send", busy, 1);
        check("ign_hold_byte0", out_data, 8'h34);
        wait_done(0, 1, n_wait);
        repeat (DL + 2) tick();
        check("ign_no_restart_busy", busy, 0);
        check("ign_no_restart_valid", out_valid, 0);
        check("ign_q_empty", exp_q.size(), 0);
        check("ign_done_cnt", done_cnt, 4);

        // Back-to-back runs
        push_stream(16'h1234, 16'h00FF, 16'h8001, 16'hFFFF);
        pulse_start();
        wait_done(0, 1, n_wait);
        check("b2b_done_high", done, 1);
        set_c(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        push_stream(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        pulse_start();
        check("b2b_busy", busy, 1);
        repeat (DL - 1) tick();
        check("b2b_pre_valid", out_valid, 0);
        tick();
        check("b2b_valid", out_valid, 1);
        check("b2b_byte0", out_data, 8'h01);
        wait_done(0, 1, n_wait);
        tick();
        check("b2b_q_empty", exp_q.size(), 0);
        check("b2b_done_cnt", done_cnt, 6);

        // Reset mid-SEND
        set_c(16'h1234, 16'h00FF, 16'h8001, 16'hFFFF);
        push_stream(16'h1234, 16'h00FF, 16'h8001, 16'hFFFF);
        pulse_start();
        repeat (DL) tick();
        repeat (3) tick();
        check("rst_mid_consumed", exp_q.size(), NB - 3);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_data", out_data, 0);
        exp_q.delete();
        dc_snap = done_cnt;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        check("rst_mid_no_done", done_cnt, dc_snap);
        check("rst_mid_idle", busy, 0);
        push_stream(16'h1234, 16'h00FF, 16'h8001, 16'hFFFF);
        pulse_start();
        wait_done(0, 1, n_wait);
        tick();
        check("rst_restart_q_empty", exp_q.size(), 0);
        check("rst_restart_done_cnt", done_cnt, dc_snap + 1);

        // Random values with random backpressure
        for (int t = 0; t < 3; t++) begin
            set_c(ACC_W'($urandom_range(0, 65535)), ACC_W'($urandom_range(0, 65535)),
                  ACC_W'($urandom_range(0, 65535)), ACC_W'($urandom_range(0, 65535)));
            push_stream(c00, c01, c10, c11);
            pulse_start();
            wait_done(2, 1, n_wait);
            tick();
            check("rand_q_empty", exp_q.size(), 0);
        end
        check("rand_done_cnt", done_cnt, dc_snap + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
